// File: rtl/wormhole_output_arbiter_pkg.sv
// Shared flit definitions for the router output stage.
//   flit_tag_e    : packet position tag carried in the top 2 flit bits
//   flit_t        : tag + payload (34 bits total)
//   routed_flit_t : flit plus routing target and last-flit flag
//   arb_state_e   : output arbiter grant state
package wormhole_output_arbiter_pkg;
    localparam int ROUTE_TARGET_W = 3;
    localparam int PAYLOAD_W      = 32;

    typedef enum logic [1:0] {START, BODY, TAIL, START_AND_END} flit_tag_e;

    typedef struct packed {
        flit_tag_e              tag;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    typedef struct packed {
        flit_t                    flit;
        logic [ROUTE_TARGET_W-1:0] target;
        logic                      last;
    } routed_flit_t;

    typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/wormhole_output_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   any : at least one request
//   idx : first requester scanning ptr, ptr+1, ... modulo N (0 when none)
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    int j;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) idx = IW'(j);
        end
    end
endmodule

// File: rtl/wormhole_output_arbiter.sv
// Per-output-port wormhole arbiter. Filters routed flits whose target equals
// PORT_ID, grants one input per packet round-robin and holds the grant until
// the last flit is accepted. Zero-cycle data path, registered grant state.
//   clk, rst        : clock, async active-high reset
//   in_valid/ready  : per-input flit handshake
//   in_flit         : per-input payload, packed NUM_INPUTS*FLIT_W
//   in_target       : per-input routing target, packed NUM_INPUTS*TARGET_W
//   in_last         : per-input last-flit flag
//   out_valid/ready : output flit handshake
//   out_flit        : selected payload
//   grant_idx       : selected input (meaningful when out_valid)
//   pkt_count       : wrapping count of forwarded packets
//   protocol_error  : sticky stream/target contract violation flag
module wormhole_output_arbiter
    import wormhole_output_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int FLIT_W     = 34,
    parameter int TARGET_W   = ROUTE_TARGET_W,
    parameter int PORT_ID    = 0,
    parameter int CNT_W      = 16,
    localparam int IW        = $clog2(NUM_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUTS-1:0]          in_valid,
    output logic [NUM_INPUTS-1:0]          in_ready,
    input  logic [NUM_INPUTS*FLIT_W-1:0]   in_flit,
    input  logic [NUM_INPUTS*TARGET_W-1:0] in_target,
    input  logic [NUM_INPUTS-1:0]          in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FLIT_W-1:0]              out_flit,
    output logic [IW-1:0]                  grant_idx,
    output logic [CNT_W-1:0]               pkt_count,
    output logic                           protocol_error
);
    logic [NUM_INPUTS-1:0][FLIT_W-1:0]   flit_a;
    logic [NUM_INPUTS-1:0][TARGET_W-1:0] tgt_a;
    logic [NUM_INPUTS-1:0]               req;
    logic                                req_any;
    logic [IW-1:0]                       win_idx;

    arb_state_e    state, state_d;
    logic [IW-1:0] lock_idx, lock_d;
    logic [IW-1:0] rr_ptr, ptr_d;
    logic [IW-1:0] sel;
    logic          selected;
    logic          cnt_inc;
    logic          err_d;
    logic          stall_q;
    logic [IW-1:0] stall_idx;

    assign flit_a = in_flit;
    assign tgt_a  = in_target;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
        assign req[i] = in_valid[i] && (tgt_a[i] == TARGET_W'(PORT_ID));
    end

    rr_arbiter #(.N(NUM_INPUTS), .IW(IW)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .any (req_any),
        .idx (win_idx)
    );

    // Explicit wrap: NUM_INPUTS need not be a power of two.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NUM_INPUTS - 1)) ? '0 : x + 1'b1;
    endfunction

    // Output mux and per-input ready.
    always_comb begin
        sel       = (state == LOCKED) ? lock_idx : win_idx;
        selected  = (state == LOCKED) || req_any;
        out_valid = (state == LOCKED) ? in_valid[lock_idx] : req_any;
        out_flit  = flit_a[sel];
        grant_idx = selected ? sel : '0;
        in_ready  = '0;
        if (selected) in_ready[sel] = out_ready;
    end

    // Lock on valid alone so a stalled flit cannot be displaced by a
    // higher-priority newcomer; only a single-flit accept stays in IDLE.
    always_comb begin
        state_d = state;
        lock_d  = lock_idx;
        ptr_d   = rr_ptr;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (out_ready && in_last[win_idx]) begin
                        ptr_d   = wrap_inc(win_idx);
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = LOCKED;
                        lock_d  = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (in_valid[lock_idx] && out_ready && in_last[lock_idx]) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(lock_idx);
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Target drift inside a packet, or valid retracted while stalled.
        err_d = ((state == LOCKED) && in_valid[lock_idx] &&
                 (tgt_a[lock_idx] != TARGET_W'(PORT_ID))) ||
                (stall_q && !in_valid[stall_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lock_idx       <= '0;
            rr_ptr         <= '0;
            pkt_count      <= '0;
            protocol_error <= 1'b0;
            stall_q        <= 1'b0;
            stall_idx      <= '0;
        end else begin
            state     <= state_d;
            lock_idx  <= lock_d;
            rr_ptr    <= ptr_d;
            stall_q   <= out_valid && !out_ready;
            stall_idx <= sel;
            if (cnt_inc) pkt_count <= pkt_count + 1'b1;
            if (err_d) protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wormhole_output_arbiter.sv
module tb_wormhole_output_arbiter;
    import wormhole_output_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int FW = 34;
    localparam int TW = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*FW-1:0] in_flit = '0;
    logic [N*TW-1:0] in_target = '0;
    logic [N-1:0]    in_last = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [FW-1:0]   out_flit;
    logic [2:0]      grant_idx;
    logic [CW-1:0]   pkt_count;
    logic            protocol_error;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wormhole_output_arbiter #(
        .NUM_INPUTS(N), .FLIT_W(FW), .TARGET_W(TW), .PORT_ID(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .in_target(in_target), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .grant_idx(grant_idx), .pkt_count(pkt_count),
        .protocol_error(protocol_error)
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] tag, input logic [31:0] pl);
        return {tag, pl};
    endfunction

    task automatic drive(input int i, input logic v, input logic [1:0] tag,
                         input logic [31:0] pl, input logic [2:0] tgt, input logic last);
        in_valid[i]          = v;
        in_flit[i*FW +: FW]  = {tag, pl};
        in_target[i*TW +: TW] = tgt;
        in_last[i]           = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = '0; in_flit = '0; in_target = '0; in_last = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, grant_idx, pkt_count, protocol_error} !== {1'b0, 5'b0, 3'd0, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got v=%b rdy=%b g=%0d cnt=%0d err=%b want 0/00000/0/0/0",
                     out_valid, in_ready, grant_idx, pkt_count, protocol_error);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        logic [FW-1:0] exp;
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(2, 1'b1, 2'(c), 32'hA0 + 32'(c), 3'd0, c == 2);
            exp = mk(2'(c), 32'hA0 + 32'(c));
            #1;
            vectors++;
            if ({out_valid, grant_idx, in_ready, out_flit} !== {1'b1, 3'd2, 5'b00100, exp}) begin
                miscompares++;
                $display("FAIL single c%0d: got v=%b g=%0d rdy=%b flit=%h want v=1 g=2 rdy=00100 flit=%h",
                         c, out_valid, grant_idx, in_ready, out_flit, exp);
            end
            tick();
        end
        drive(2, 1'b0, 2'd0, 32'h0, 3'd0, 1'b0);
        #1;
        vectors++;
        if ({out_valid, in_ready, pkt_count} !== {1'b0, 5'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL single_done: got v=%b rdy=%b cnt=%0d want v=0 rdy=00000 cnt=1",
                     out_valid, in_ready, pkt_count);
        end
    endtask

    task automatic test_two_inputs();
        apply_reset();
        out_ready = 1'b1;
        drive(0, 1'b1, START, 32'h10, 3'd0, 1'b0);
        drive(1, 1'b1, START, 32'h20, 3'd0, 1'b0);
        #1;
        vectors++;
        if ({grant_idx, in_ready, out_flit} !== {3'd0, 5'b00001, mk(START, 32'h10)}) begin
            miscompares++;
            $display("FAIL two c0: got g=%0d rdy=%b flit=%h want g=0 rdy=00001", grant_idx, in_ready, out_flit);
        end
        tick();
        drive(0, 1'b1, TAIL, 32'h11, 3'd0, 1'b1);
        #1;
        vectors++;
        if ({grant_idx, in_ready, out_flit} !== {3'd0, 5'b00001, mk(TAIL, 32'h11)}) begin
            miscompares++;
            $display("FAIL two c1: got g=%0d rdy=%b flit=%h want g=0 rdy=00001", grant_idx, in_ready, out_flit);
        end
        tick();
        // Single IDLE (re-arbitration) cycle: input 1 presented straight away.
        drive(0, 1'b0, START, 32'h0, 3'd0, 1'b0);
        #1;
        vectors++;
        if ({out_valid, grant_idx, in_ready, out_flit, pkt_count} !== {1'b1, 3'd1, 5'b00010, mk(START, 32'h20), 16'd1}) begin
            miscompares++;
            $display("FAIL two c2: got v=%b g=%0d rdy=%b flit=%h cnt=%0d want v=1 g=1 rdy=00010 cnt=1",
                     out_valid, grant_idx, in_ready, out_flit, pkt_count);
        end
        tick();
        drive(1, 1'b1, TAIL, 32'h21, 3'd0, 1'b1);
        #1;
        vectors++;
        if ({grant_idx, out_flit} !== {3'd1, mk(TAIL, 32'h21)}) begin
            miscompares++;
            $display("FAIL two c3: got g=%0d flit=%h want g=1", grant_idx, out_flit);
        end
        tick();
        drive(1, 1'b0, START, 32'h0, 3'd0, 1'b0);
        #1;
        vectors++;
        if ({out_valid, pkt_count} !== {1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL two_done: got v=%b cnt=%0d want v=0 cnt=2", out_valid, pkt_count);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 1'b0;
        drive(3, 1'b1, START, 32'h30, 3'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive(1, 1'b1, START, 32'h40, 3'd0, 1'b0);
            #1;
            vectors++;
            if ({out_valid, grant_idx, in_ready, out_flit} !== {1'b1, 3'd3, 5'b00000, mk(START, 32'h30)}) begin
                miscompares++;
                $display("FAIL stall c%0d: got v=%b g=%0d rdy=%b flit=%h want v=1 g=3 rdy=00000",
                         c, out_valid, grant_idx, in_ready, out_flit);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if ({grant_idx, in_ready} !== {3'd3, 5'b01000}) begin
            miscompares++;
            $display("FAIL stall_release: got g=%0d rdy=%b want g=3 rdy=01000", grant_idx, in_ready);
        end
        tick();
        drive(3, 1'b1, TAIL, 32'h31, 3'd0, 1'b1);
        #1;
        vectors++;
        if ({grant_idx, in_ready, out_flit} !== {3'd3, 5'b01000, mk(TAIL, 32'h31)}) begin
            miscompares++;
            $display("FAIL stall_tail: got g=%0d rdy=%b flit=%h want g=3 rdy=01000", grant_idx, in_ready, out_flit);
        end
        tick();
        drive(3, 1'b0, START, 32'h0, 3'd0, 1'b0);
        #1;
        vectors++;
        if ({out_valid, grant_idx, in_ready, protocol_error} !== {1'b1, 3'd1, 5'b00010, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_next: got v=%b g=%0d rdy=%b err=%b want v=1 g=1 rdy=00010 err=0",
                     out_valid, grant_idx, in_ready, protocol_error);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b1, START_AND_END, 32'(i), 3'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if ({out_valid, grant_idx, out_flit, pkt_count} !== {1'b1, 3'(k % N), mk(START_AND_END, 32'(k % N)), 16'(k)}) begin
                miscompares++;
                $display("FAIL rotate k%0d: got v=%b g=%0d flit=%h cnt=%0d want v=1 g=%0d cnt=%0d",
                         k, out_valid, grant_idx, out_flit, pkt_count, k % N, k);
            end
            tick();
        end
    endtask

    task automatic test_wrong_target();
        apply_reset();
        out_ready = 1'b1;
        drive(0, 1'b1, START_AND_END, 32'h55, 3'd2, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({out_valid, in_ready, protocol_error, pkt_count} !== {1'b0, 5'b0, 1'b0, 16'd0}) begin
                miscompares++;
                $display("FAIL wrong_target c%0d: got v=%b rdy=%b err=%b cnt=%0d want 0/00000/0/0",
                         c, out_valid, in_ready, protocol_error, pkt_count);
            end
            tick();
        end
    endtask

    task automatic test_valid_drop();
        apply_reset();
        out_ready = 1'b0;
        drive(2, 1'b1, START, 32'h77, 3'd0, 1'b0);
        tick();
        drive(2, 1'b0, START, 32'h77, 3'd0, 1'b0);
        tick();
        vectors++;
        if (protocol_error !== 1'b1) begin
            miscompares++;
            $display("FAIL valid_drop: got err=%b want 1", protocol_error);
        end
    endtask

    task automatic test_target_change();
        apply_reset();
        out_ready = 1'b1;
        drive(1, 1'b1, START, 32'h90, 3'd0, 1'b0);
        tick();
        drive(1, 1'b1, BODY, 32'h91, 3'd4, 1'b0);
        #1;
        vectors++;
        if ({out_valid, grant_idx, protocol_error} !== {1'b1, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL tgt_change c1: got v=%b g=%0d err=%b want v=1 g=1 err=0",
                     out_valid, grant_idx, protocol_error);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (protocol_error !== 1'b1) begin
                miscompares++;
                $display("FAIL tgt_sticky c%0d: got err=%b want 1", c, protocol_error);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({protocol_error, pkt_count, out_valid, in_ready} !== {1'b0, 16'd0, 1'b0, 5'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got err=%b cnt=%0d v=%b rdy=%b want 0/0/0/00000",
                     protocol_error, pkt_count, out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_two_inputs();
        test_stall();
        test_back_to_back();
        test_wrong_target();
        test_valid_drop();
        test_target_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
